key_debounce_multi: RTL and testbench

Multi-channel key debouncer with press, release, long-press and auto-repeat event strobes. It generalises the single-key `debounce` block to KEYS_CNT independent active-low inputs. Each channel gets an input synchroniser, a stability counter and a hold-time state machine. It sits between the board push-buttons and the lab control logic, one clock domain.

---
 rtl/key_debounce_multi.sv | 188 ++++++++++++++++++
 tb/tb_key_debounce_multi.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_multi.sv
// key_debounce_multi: KEYS_CNT independent active-low key debouncers.
// Each channel has a 2-flop synchroniser, a stability counter that accepts
// a level change after DELAY_CYCLES consecutive disagreeing samples, and a
// hold FSM that emits long-press and auto-repeat strobes while held.

module key_debounce_ch #(
    parameter int DELAY_CYCLES  = 4,
    parameter int LONG_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_key,
    output logic o_pressed,
    output logic o_press_stb,
    output logic o_release_stb,
    output logic o_long_stb,
    output logic o_repeat_stb
);
    localparam int CW   = $clog2(DELAY_CYCLES + 1);
    localparam int HMAX = (LONG_CYCLES > REPEAT_CYCLES) ? LONG_CYCLES : REPEAT_CYCLES;
    localparam int HW   = $clog2(HMAX + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DELAY_CYCLES - 1);
    localparam logic [HW-1:0] LONG_LAST = HW'(LONG_CYCLES - 1);
    // Guard the zero case so the constant never goes negative.
    localparam logic [HW-1:0] REP_LAST  = HW'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_RELEASED  = 2'd0,
        S_HELD      = 2'd1,
        S_HELD_LONG = 2'd2
    } state_t;

    logic          r_sync1, r_sync2;
    logic [CW-1:0] r_cnt;
    logic          r_pressed;
    state_t        r_state;
    logic [HW-1:0] r_hcnt;
    logic          r_press_stb, r_release_stb, r_long_stb, r_repeat_stb;

    logic          w_sync;
    logic          w_accept;
    logic          w_press_evt, w_release_evt;
    state_t        w_state_nxt;
    logic [HW-1:0] w_hcnt_nxt;
    logic          w_long_evt, w_repeat_evt;

    // Synchronised key, converted to active-high (1 = pressed).
    assign w_sync        = ~r_sync2;
    assign w_accept      = (w_sync != r_pressed) && (r_cnt == CNT_LAST);
    assign w_press_evt   = w_accept && !r_pressed;
    assign w_release_evt = w_accept &&  r_pressed;

    // Two-flop synchroniser on the raw key; resets to the released level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= i_key;
            r_sync2 <= r_sync1;
        end
    end

    // Stability counter: any agreeing sample restarts the count.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt     <= '0;
            r_pressed <= 1'b0;
        end else if (w_sync == r_pressed) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt     <= '0;
            r_pressed <= ~r_pressed;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // Hold FSM state and hold counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_RELEASED;
            r_hcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hcnt  <= w_hcnt_nxt;
        end
    end

    // Hold FSM next state; an accepted release wins over long/repeat.
    always_comb begin
        w_state_nxt  = r_state;
        w_hcnt_nxt   = r_hcnt;
        w_long_evt   = 1'b0;
        w_repeat_evt = 1'b0;
        case (r_state)
            S_RELEASED: begin
                w_hcnt_nxt = '0;
                if (w_press_evt) w_state_nxt = S_HELD;
            end
            S_HELD: begin
                if (w_release_evt) begin
                    w_state_nxt = S_RELEASED;
                    w_hcnt_nxt  = '0;
                end else if (r_hcnt == LONG_LAST) begin
                    w_state_nxt = S_HELD_LONG;
                    w_hcnt_nxt  = '0;
                    w_long_evt  = 1'b1;
                end else begin
                    w_hcnt_nxt = r_hcnt + HW'(1);
                end
            end
            S_HELD_LONG: begin
                if (w_release_evt) begin
                    w_state_nxt = S_RELEASED;
                    w_hcnt_nxt  = '0;
                end else if (REPEAT_CYCLES == 0) begin
                    w_hcnt_nxt = '0;
                end else if (r_hcnt == REP_LAST) begin
                    w_hcnt_nxt   = '0;
                    w_repeat_evt = 1'b1;
                end else begin
                    w_hcnt_nxt = r_hcnt + HW'(1);
                end
            end
            default: begin
                w_state_nxt = S_RELEASED;
                w_hcnt_nxt  = '0;
            end
        endcase
    end

    // Registered strobes, aligned with the new debounced level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_press_stb   <= 1'b0;
            r_release_stb <= 1'b0;
            r_long_stb    <= 1'b0;
            r_repeat_stb  <= 1'b0;
        end else begin
            r_press_stb   <= w_press_evt;
            r_release_stb <= w_release_evt;
            r_long_stb    <= w_long_evt;
            r_repeat_stb  <= w_repeat_evt;
        end
    end

    assign o_pressed     = r_pressed;
    assign o_press_stb   = r_press_stb;
    assign o_release_stb = r_release_stb;
    assign o_long_stb    = r_long_stb;
    assign o_repeat_stb  = r_repeat_stb;
endmodule

module key_debounce_multi #(
    parameter int KEYS_CNT      = 4,
    parameter int DELAY_CYCLES  = 4,
    parameter int LONG_CYCLES   = 16,
    parameter int REPEAT_CYCLES = 8
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [KEYS_CNT-1:0] key_i,
    output logic [KEYS_CNT-1:0] pressed_o,
    output logic [KEYS_CNT-1:0] press_stb_o,
    output logic [KEYS_CNT-1:0] release_stb_o,
    output logic [KEYS_CNT-1:0] long_stb_o,
    output logic [KEYS_CNT-1:0] repeat_stb_o
);
    // One fully independent debouncer per key.
    for (genvar g = 0; g < KEYS_CNT; g++) begin : g_ch
        key_debounce_ch #(
            .DELAY_CYCLES (DELAY_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES)
        ) u_ch (
            .i_clk        (clk_i),
            .i_rst        (rst_i),
            .i_key        (key_i[g]),
            .o_pressed    (pressed_o[g]),
            .o_press_stb  (press_stb_o[g]),
            .o_release_stb(release_stb_o[g]),
            .o_long_stb   (long_stb_o[g]),
            .o_repeat_stb (repeat_stb_o[g])
        );
    end
endmodule

// File: tb/tb_key_debounce_multi.sv
// Bench for key_debounce_multi: a 2-key instance with repeat and a 1-key
// instance with repeat disabled, checked cycle by cycle against an
// event-time reference model.

module tb_key_debounce_multi;
    localparam int D = 4;
    localparam int L = 16;
    localparam int R = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [1:0] key;
    logic [0:0] keyb;
    logic [1:0] pr, ps, rs, lg, rp;
    logic [0:0] pr0, ps0, rs0, lg0, rp0;

    key_debounce_multi #(.KEYS_CNT(2), .DELAY_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(R)) dut (
        .clk_i(clk), .rst_i(rst), .key_i(key), .pressed_o(pr), .press_stb_o(ps),
        .release_stb_o(rs), .long_stb_o(lg), .repeat_stb_o(rp));

    key_debounce_multi #(.KEYS_CNT(1), .DELAY_CYCLES(D), .LONG_CYCLES(L), .REPEAT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_i(rst), .key_i(keyb), .pressed_o(pr0), .press_stb_o(ps0),
        .release_stb_o(rs0), .long_stb_o(lg0), .repeat_stb_o(rp0));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: channels 0,1 = dut, channel 2 = dut0 (no repeat).
    logic [2:0]   ms1, ms2, mp, ep, er, el, erp;
    logic [D-1:0] hist [3];
    int           ptime [3];

    wire [9:0] obs_main = {pr, ps, rs, lg, rp};
    wire [4:0] obs_alt  = {pr0, ps0, rs0, lg0, rp0};

    function automatic logic [9:0] exp_main();
        return {mp[1:0], ep[1:0], er[1:0], el[1:0], erp[1:0]};
    endfunction

    function automatic logic [4:0] exp_alt();
        return {mp[2], ep[2], er[2], el[2], erp[2]};
    endfunction

    task automatic model_reset();
        ms1 = '1; ms2 = '1; mp = '0; ep = '0; er = '0; el = '0; erp = '0;
        for (int c = 0; c < 3; c++) begin
            hist[c]  = '0;
            ptime[c] = 0;
        end
    endtask

    // Level flips once the last D synchronised samples all disagree; events
    // are then timed by age since the accepted press.
    task automatic model_step();
        logic [2:0] raw;
        logic       s;
        int         age, rr;
        cyc++;
        if (rst) begin
            model_reset();
            return;
        end
        raw = {keyb[0], key};
        for (int c = 0; c < 3; c++) begin
            s       = ~ms2[c];
            ms2[c]  = ms1[c];
            ms1[c]  = raw[c];
            hist[c] = {hist[c][D-2:0], s};
            ep[c] = 1'b0; er[c] = 1'b0; el[c] = 1'b0; erp[c] = 1'b0;
            rr = (c == 2) ? 0 : R;
            if (mp[c] ? (hist[c] == '0) : (hist[c] == '1)) begin
                mp[c] = ~mp[c];
                if (mp[c]) begin
                    ep[c]    = 1'b1;
                    ptime[c] = cyc;
                end else begin
                    er[c] = 1'b1;
                end
            end else if (mp[c]) begin
                age = cyc - ptime[c];
                if (age == L) el[c] = 1'b1;
                else if (rr != 0 && age > L && ((age - L) % rr) == 0) erp[c] = 1'b1;
            end
        end
    endtask

    // Drive inputs at the falling edge, step the model at the rising edge,
    // return at the next falling edge for sampling.
    task automatic tick(input logic [1:0] k, input logic kb);
        key     = k;
        keyb[0] = kb;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; key = 2'b11; keyb = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({obs_main, obs_alt} !== 15'd0) begin
            errors++;
            $display("FAIL reset_async: got %b want 0", {obs_main, obs_alt});
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            tick(2'b11, 1'b1);
            checks++;
            if ({obs_main, obs_alt} !== 15'd0) begin
                errors++;
                $display("FAIL reset_hold: got %b want 0", {obs_main, obs_alt});
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 8; i++) tick(2'b11, 1'b1);
    endtask

    task automatic test_clean_press();
        int t_press, t_long, t_rel, n_rep, n_ch1;
        int t_rep [2];
        t_press = -1; t_long = -1; t_rel = -1; n_rep = 0; n_ch1 = 0;
        t_rep[0] = -1; t_rep[1] = -1;
        for (int i = 1; i <= 52; i++) begin
            tick((i <= 40) ? 2'b10 : 2'b11, 1'b1);
            checks++;
            if (obs_main !== exp_main()) begin
                errors++;
                $display("FAIL clean_press tick %0d: got %b want %b", i, obs_main, exp_main());
            end
            if (ps[0]) t_press = i;
            if (lg[0]) t_long = i;
            if (rs[0]) t_rel = i;
            if (rp[0]) begin
                if (n_rep < 2) t_rep[n_rep] = i;
                n_rep++;
            end
            if (ps[1] | rs[1] | lg[1] | rp[1] | pr[1]) n_ch1++;
        end
        checks++;
        if (t_press != 6 || t_long != 22 || t_rel != 46) begin
            errors++;
            $display("FAIL clean_press_times: got press %0d long %0d rel %0d want 6 22 46", t_press, t_long, t_rel);
        end
        checks++;
        if (n_rep != 2 || t_rep[0] != 30 || t_rep[1] != 38) begin
            errors++;
            $display("FAIL clean_press_repeat: got n=%0d at %0d,%0d want 2 at 30,38", n_rep, t_rep[0], t_rep[1]);
        end
        checks++;
        if (n_ch1 != 0) begin
            errors++;
            $display("FAIL clean_press_ch1_silent: got %0d active cycles want 0", n_ch1);
        end
    endtask

    task automatic test_bounce();
        logic [1:0] pat [14];
        int n_p, n_r, n_l;
        n_p = 0; n_r = 0; n_l = 0;
        pat[0] = 2'b01; pat[1] = 2'b11; pat[2] = 2'b01; pat[3] = 2'b11;
        for (int i = 4; i < 10; i++) pat[i] = 2'b01;
        for (int i = 10; i < 14; i++) pat[i] = 2'b11;
        for (int i = 0; i < 24; i++) begin
            tick((i < 14) ? pat[i] : 2'b11, 1'b1);
            checks++;
            if (obs_main !== exp_main()) begin
                errors++;
                $display("FAIL bounce tick %0d: got %b want %b", i, obs_main, exp_main());
            end
            n_p += int'(ps[1]); n_r += int'(rs[1]); n_l += int'(lg[1]);
        end
        checks++;
        if (n_p != 1 || n_r != 1 || n_l != 0) begin
            errors++;
            $display("FAIL bounce_counts: got press %0d rel %0d long %0d want 1 1 0", n_p, n_r, n_l);
        end
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 12; i++) begin
            tick((i < D - 1) ? 2'b10 : 2'b11, 1'b1);
            checks++;
            if (obs_main !== 10'd0 || obs_main !== exp_main()) begin
                errors++;
                $display("FAIL glitch tick %0d: got %b want 0", i, obs_main);
            end
        end
    endtask

    task automatic test_no_repeat();
        int n_l, n_r;
        n_l = 0; n_r = 0;
        for (int i = 0; i < 72; i++) begin
            tick(2'b11, (i < 60) ? 1'b0 : 1'b1);
            checks++;
            if (obs_alt !== exp_alt()) begin
                errors++;
                $display("FAIL no_repeat tick %0d: got %b want %b", i, obs_alt, exp_alt());
            end
            n_l += int'(lg0[0]); n_r += int'(rp0[0]);
        end
        checks++;
        if (n_l != 1 || n_r != 0) begin
            errors++;
            $display("FAIL no_repeat_counts: got long %0d rep %0d want 1 0", n_l, n_r);
        end
    endtask

    task automatic test_reset_mid();
        int t_press, t_long;
        t_press = -1; t_long = -1;
        for (int i = 0; i < 30; i++) tick(2'b10, 1'b1);
        checks++;
        if (pr[0] !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_pre: got pressed %b want 1", pr[0]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({obs_main, obs_alt} !== 15'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got %b want 0", {obs_main, obs_alt});
        end
        @(negedge clk);
        tick(2'b10, 1'b1);
        tick(2'b10, 1'b1);
        rst = 1'b0;
        for (int i = 1; i <= 26; i++) begin
            tick(2'b10, 1'b1);
            checks++;
            if (obs_main !== exp_main()) begin
                errors++;
                $display("FAIL reset_mid tick %0d: got %b want %b", i, obs_main, exp_main());
            end
            if (ps[0] && t_press < 0) t_press = i;
            if (lg[0] && t_long < 0) t_long = i;
        end
        checks++;
        if (t_press != 6 || t_long != 22) begin
            errors++;
            $display("FAIL reset_mid_times: got press %0d long %0d want 6 22", t_press, t_long);
        end
        for (int i = 0; i < 10; i++) tick(2'b11, 1'b1);
    endtask

    task automatic test_both();
        for (int i = 1; i <= 30; i++) begin
            tick((i <= 24) ? 2'b00 : 2'b11, 1'b1);
            checks++;
            if (obs_main !== exp_main()) begin
                errors++;
                $display("FAIL both tick %0d: got %b want %b", i, obs_main, exp_main());
            end
            if (i == 6 || i == 22) begin
                checks++;
                if ((i == 6 ? ps : lg) !== 2'b11) begin
                    errors++;
                    $display("FAIL both_coincide tick %0d: got ps %b lg %b want 11", i, ps, lg);
                end
            end
        end
        for (int i = 0; i < 8; i++) tick(2'b11, 1'b1);
    endtask

    task automatic test_random();
        logic [2:0] lvl;
        int         left [3];
        lvl = 3'b111;
        for (int c = 0; c < 3; c++) left[c] = 1;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < 3; c++) begin
                left[c]--;
                if (left[c] <= 0) begin
                    lvl[c]  = ~lvl[c];
                    left[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 60))
                                                          : int'($urandom_range(1, 7));
                end
            end
            tick(lvl[1:0], lvl[2]);
            checks++;
            if ({obs_main, obs_alt} !== {exp_main(), exp_alt()}) begin
                errors++;
                $display("FAIL random tick %0d: got %b want %b", i, {obs_main, obs_alt}, {exp_main(), exp_alt()});
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_glitch();
        test_no_repeat();
        test_reset_mid();
        test_both();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
